// File: rtl/ysyx_24100006_redirect_ctrl_pkg.sv
// Shared definitions for the redirect sequencer: FSM encoding, flush masks,
// and the width helper for the outstanding-fetch counter.
package ysyx_24100006_redirect_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        REDIR = 2'd2
    } redir_state_e;

    // Flush masks, bit order {ex_mem, id_ex, if_id}
    localparam logic [2:0] FLUSH_BR   = 3'b011;
    localparam logic [2:0] FLUSH_TRAP = 3'b111;

    // Counter width able to hold 0..max inclusive
    function automatic int cnt_width(input int max);
        return $clog2(max + 1);
    endfunction

endpackage

// File: rtl/ysyx_24100006_redirect_ctrl_if.sv
// IFU-side bus of the redirect sequencer: fetch request/response fire
// strobes, the wrong-path kill and fetch hold, and the new-PC handshake.
// master = redirect controller, slave = IFU.
interface ysyx_24100006_redirect_ctrl_if;
    import ysyx_24100006_redirect_ctrl_pkg::*;

    logic        ifu_req_fire;
    logic        ifu_rsp_fire;
    logic        rsp_kill;
    logic        fetch_hold;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    modport master (
        input  ifu_req_fire, ifu_rsp_fire, redirect_ready,
        output rsp_kill, fetch_hold, redirect_valid, redirect_pc
    );

    modport slave (
        output ifu_req_fire, ifu_rsp_fire, redirect_ready,
        input  rsp_kill, fetch_hold, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/ysyx_24100006_outst_cnt.sv
// Up/down counter saturating at 0 and MAX, with a full flag.
// Exposes its next value so callers can snapshot the post-update count.
module ysyx_24100006_outst_cnt
    import ysyx_24100006_redirect_ctrl_pkg::*;
#(
    parameter int MAX = 2,
    parameter int W   = cnt_width(MAX)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt_nxt,
    output logic         full
);

    localparam logic [W-1:0] MAXV = W'(MAX);

    logic [W-1:0] cnt;

    // Next count; simultaneous inc/dec cancel, a decrement at zero is dropped
    always_comb begin
        cnt_nxt = cnt;
        if (inc && !dec && cnt != MAXV)
            cnt_nxt = cnt + W'(1);
        else if (dec && !inc && cnt != '0)
            cnt_nxt = cnt - W'(1);
    end

    // Count register
    always_ff @(posedge clk) begin
        if (reset) cnt <= '0;
        else       cnt <= cnt_nxt;
    end

    assign full = (cnt == MAXV);

endmodule

// File: rtl/ysyx_24100006_redirect_ctrl.sv
// Control-flow redirect sequencer: accepts EXU branch mispredicts and WBU
// trap targets, flushes the stage registers, drains in-flight wrong-path
// fetch responses, then hands the new PC to the IFU.
// Optional: REDIRECT_PERF_EN adds branch/trap/drain-cycle perf counters.
module ysyx_24100006_redirect_ctrl
    import ysyx_24100006_redirect_ctrl_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exu_redir_valid,
    input  logic [31:0] exu_redir_pc,
    input  logic        wbu_trap_valid,
    input  logic [31:0] wbu_trap_pc,
    ysyx_24100006_redirect_ctrl_if.master ifu,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        flush_ex_mem
`ifdef REDIRECT_PERF_EN
    ,
    output logic [31:0] perf_branch_cnt,
    output logic [31:0] perf_trap_cnt,
    output logic [31:0] perf_drain_cyc
`endif
);

    localparam int CW = cnt_width(MAX_OUTSTANDING);

    redir_state_e  state_q, state_d;
    logic [31:0]   pc_q;
    logic [CW-1:0] kill_cnt, kill_nxt;
    logic [CW-1:0] outst_nxt;
    logic          outst_full;
    logic [2:0]    flush;
    logic          trap_acc, br_acc, accept, kill_fire;

    ysyx_24100006_outst_cnt #(.MAX(MAX_OUTSTANDING), .W(CW)) u_outst (
        .clk     (clk),
        .reset   (reset),
        .inc     (ifu.ifu_req_fire),
        .dec     (ifu.ifu_rsp_fire),
        .cnt_nxt (outst_nxt),
        .full    (outst_full)
    );

    // Traps are taken anywhere; branches only on the correct path (RUN)
    assign trap_acc  = wbu_trap_valid;
    assign br_acc    = exu_redir_valid && !wbu_trap_valid && (state_q == RUN);
    assign accept    = trap_acc || br_acc;
    assign kill_fire = (state_q == DRAIN) && ifu.ifu_rsp_fire && (kill_cnt != '0);
    assign kill_nxt  = kill_fire ? kill_cnt - CW'(1) : kill_cnt;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= RUN;
        else       state_q <= state_d;
    end

    // Next state; a fresh event restarts the drain from the live fetch count
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = (outst_nxt != '0) ? DRAIN : REDIR;
        end else begin
            case (state_q)
                RUN:     state_d = RUN;
                DRAIN:   if (kill_nxt == '0) state_d = REDIR;
                REDIR:   if (ifu.redirect_ready) state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    // Target PC and the number of responses still to discard
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= '0;
            kill_cnt <= '0;
        end else if (accept) begin
            pc_q     <= trap_acc ? wbu_trap_pc : exu_redir_pc;
            kill_cnt <= outst_nxt;
        end else begin
            kill_cnt <= kill_nxt;
        end
    end

    // Outputs: flushes are zero-latency from the accepted event
    always_comb begin
        flush = '0;
        if (trap_acc)    flush = FLUSH_TRAP;
        else if (br_acc) flush = FLUSH_BR;
        ifu.rsp_kill       = kill_fire;
        ifu.fetch_hold     = (state_q == RUN) ? outst_full : 1'b1;
        ifu.redirect_valid = (state_q == REDIR);
        ifu.redirect_pc    = (state_q == REDIR) ? pc_q : '0;
    end

    assign flush_if_id  = flush[0];
    assign flush_id_ex  = flush[1];
    assign flush_ex_mem = flush[2];

`ifdef REDIRECT_PERF_EN
    // Event and redirect-latency counters, wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_branch_cnt <= '0;
            perf_trap_cnt   <= '0;
            perf_drain_cyc  <= '0;
        end else begin
            if (br_acc)           perf_branch_cnt <= perf_branch_cnt + 32'd1;
            if (trap_acc)         perf_trap_cnt   <= perf_trap_cnt + 32'd1;
            if (state_q != RUN)   perf_drain_cyc  <= perf_drain_cyc + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_24100006_redirect_ctrl.sv
// Directed, table-driven bench for the redirect sequencer plus hand-written
// sequences for reset abort and the optional perf counters (REDIRECT_PERF_EN).
module tb_ysyx_24100006_redirect_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        exu_redir_valid;
    logic [31:0] exu_redir_pc;
    logic        wbu_trap_valid;
    logic [31:0] wbu_trap_pc;
    logic        flush_if_id, flush_id_ex, flush_ex_mem;
`ifdef REDIRECT_PERF_EN
    logic [31:0] perf_branch_cnt, perf_trap_cnt, perf_drain_cyc;
`endif

    int errors = 0;
    int checks = 0;

    ysyx_24100006_redirect_ctrl_if bus();

    ysyx_24100006_redirect_ctrl #(.MAX_OUTSTANDING(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .exu_redir_valid (exu_redir_valid),
        .exu_redir_pc    (exu_redir_pc),
        .wbu_trap_valid  (wbu_trap_valid),
        .wbu_trap_pc     (wbu_trap_pc),
        .ifu             (bus.master),
        .flush_if_id     (flush_if_id),
        .flush_id_ex     (flush_id_ex),
        .flush_ex_mem    (flush_ex_mem)
`ifdef REDIRECT_PERF_EN
        ,
        .perf_branch_cnt (perf_branch_cnt),
        .perf_trap_cnt   (perf_trap_cnt),
        .perf_drain_cyc  (perf_drain_cyc)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        tv;
        logic [31:0] tpc;
        logic        bv;
        logic [31:0] bpc;
        logic        req, rsp, rdy;
        logic [2:0]  fl;     // {ex_mem, id_ex, if_id}
        logic        kill, hold, rv;
        logic [31:0] rpc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic tv, input logic [31:0] tpc,
                                input logic bv, input logic [31:0] bpc,
                                input logic req, input logic rsp, input logic rdy,
                                input logic [2:0] fl, input logic kill,
                                input logic hold, input logic rv, input logic [31:0] rpc);
        vec_t v;
        v.tv = tv; v.tpc = tpc; v.bv = bv; v.bpc = bpc;
        v.req = req; v.rsp = rsp; v.rdy = rdy;
        v.fl = fl; v.kill = kill; v.hold = hold; v.rv = rv; v.rpc = rpc;
        return v;
    endfunction

    // Apply one cycle of inputs just after the falling edge
    task automatic drive(input logic rst, input logic tv, input logic [31:0] tpc,
                         input logic bv, input logic [31:0] bpc,
                         input logic req, input logic rsp, input logic rdy);
        @(negedge clk);
        reset               = rst;
        wbu_trap_valid      = tv;
        wbu_trap_pc         = tpc;
        exu_redir_valid     = bv;
        exu_redir_pc        = bpc;
        bus.ifu_req_fire    = req;
        bus.ifu_rsp_fire    = rsp;
        bus.redirect_ready  = rdy;
        #2;
    endtask

    task automatic check_out(input string name, input logic [2:0] fl, input logic kill,
                             input logic hold, input logic rv, input logic [31:0] rpc);
        logic [38:0] got, want;
        got  = {flush_ex_mem, flush_id_ex, flush_if_id, bus.rsp_kill,
                bus.fetch_hold, bus.redirect_valid, bus.redirect_pc};
        want = {fl, kill, hold, rv, rpc};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got flush=%b kill=%b hold=%b rv=%b pc=%h, want flush=%b kill=%b hold=%b rv=%b pc=%h",
                     name, got[38:36], got[35], got[34], got[33], got[31:0],
                     fl, kill, hold, rv, rpc);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    initial begin
        //               tv tpc           bv bpc           rq rs rdy  fl      k  h  rv rpc
        // T1: branch with nothing in flight
        vecs.push_back(mk(0, 0,            0, 0,            0, 0, 0, 3'b000, 0, 0, 0, 0));            // reset state
        vecs.push_back(mk(0, 0,            1, 32'h80000100, 0, 0, 0, 3'b011, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,            0, 0,            0, 0, 0, 3'b000, 0, 1, 1, 32'h80000100));
        vecs.push_back(mk(0, 0,            0, 0,            0, 0, 1, 3'b000, 0, 1, 1, 32'h80000100));
        vecs.push_back(mk(0, 0,            0, 0,            0, 0, 0, 3'b000, 0, 0, 0, 0));
        // T2: two in flight, branch drains two responses
        vecs.push_back(mk(0, 0,            0, 0,            1, 0, 0, 3'b000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,            0, 0,            1, 0, 0, 3'b000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,            0, 0,            0, 0, 0, 3'b000, 0, 1, 0, 0));            // full
        vecs.push_back(mk(0, 0,            1, 32'h80000040, 0, 0, 0, 3'b011, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0,            0, 0,            0, 0, 0, 3'b000, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0,            0, 0,            0, 1, 0, 3'b000, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0,            0, 0,            0, 1, 0, 3'b000, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0,            0, 0,            0, 0, 1, 3'b000, 0, 1, 1, 32'h80000040));
        vecs.push_back(mk(0, 0,            0, 0,            0, 0, 0, 3'b000, 0, 0, 0, 0));
        // T3: trap and branch together, trap wins
        vecs.push_back(mk(1, 32'h80000004, 1, 32'h80000100, 0, 0, 0, 3'b111, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,            0, 0,            0, 0, 1, 3'b000, 0, 1, 1, 32'h80000004));
        // T4: trap in DRAIN with one kill left, later branch ignored
        vecs.push_back(mk(0, 0,            0, 0,            1, 0, 0, 3'b000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,            0, 0,            1, 0, 0, 3'b000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,            1, 32'h80000200, 0, 0, 0, 3'b011, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0,            0, 0,            0, 1, 0, 3'b000, 1, 1, 0, 0));
        vecs.push_back(mk(1, 32'h80000008, 0, 0,            0, 0, 0, 3'b111, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0,            1, 32'h80000300, 0, 0, 0, 3'b000, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0,            0, 0,            0, 1, 0, 3'b000, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0,            0, 0,            0, 0, 0, 3'b000, 0, 1, 1, 32'h80000008));
        vecs.push_back(mk(0, 0,            0, 0,            0, 0, 1, 3'b000, 0, 1, 1, 32'h80000008));
        vecs.push_back(mk(0, 0,            0, 0,            0, 0, 0, 3'b000, 0, 0, 0, 0));
        // Trap while in REDIR replaces the target
        vecs.push_back(mk(0, 0,            1, 32'h80000500, 0, 0, 0, 3'b011, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h8000000c, 0, 0,            0, 0, 0, 3'b111, 0, 1, 1, 32'h80000500));
        vecs.push_back(mk(0, 0,            0, 0,            0, 0, 1, 3'b000, 0, 1, 1, 32'h8000000c));
        vecs.push_back(mk(0, 0,            0, 0,            0, 0, 0, 3'b000, 0, 0, 0, 0));
        // Response coincident with branch: nothing left to kill
        vecs.push_back(mk(0, 0,            0, 0,            1, 0, 0, 3'b000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,            1, 32'h80000600, 0, 1, 0, 3'b011, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,            0, 0,            0, 0, 1, 3'b000, 0, 1, 1, 32'h80000600));
        // Request coincident with branch: one to kill
        vecs.push_back(mk(0, 0,            1, 32'h80000700, 1, 0, 0, 3'b011, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,            0, 0,            0, 1, 0, 3'b000, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0,            0, 0,            0, 0, 1, 3'b000, 0, 1, 1, 32'h80000700));
        vecs.push_back(mk(0, 0,            0, 0,            0, 0, 0, 3'b000, 0, 0, 0, 0));

        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(0, vecs[i].tv, vecs[i].tpc, vecs[i].bv, vecs[i].bpc,
                  vecs[i].req, vecs[i].rsp, vecs[i].rdy);
            check_out($sformatf("vec%0d", i), vecs[i].fl, vecs[i].kill,
                      vecs[i].hold, vecs[i].rv, vecs[i].rpc);
        end

        // T5: REDIR stalled by ready, reset in the second stalled cycle
        drive(0, 0, 0, 1, 32'h80000800, 0, 0, 0);
        check_out("t5_branch", 3'b011, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check_out("t5_stall1", 3'b000, 0, 1, 1, 32'h80000800);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        check_out("t5_stall2", 3'b000, 0, 1, 1, 32'h80000800);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check_out("t5_after_reset", 3'b000, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check_out("t5_idle", 3'b000, 0, 0, 0, 0);

        // T6: two branches and a trap with two kills; 5 DRAIN/REDIR cycles
        drive(0, 0, 0, 1, 32'h80000900, 0, 0, 0);
        check_out("t6_br1", 3'b011, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        check_out("t6_redir1", 3'b000, 0, 1, 1, 32'h80000900);
        drive(0, 0, 0, 1, 32'h80000a00, 0, 0, 0);
        check_out("t6_br2", 3'b011, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        check_out("t6_redir2", 3'b000, 0, 1, 1, 32'h80000a00);
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        drive(0, 1, 32'h80000b00, 0, 0, 0, 0, 0);
        check_out("t6_trap", 3'b111, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        check_out("t6_kill1", 3'b000, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        check_out("t6_kill2", 3'b000, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        check_out("t6_redir3", 3'b000, 0, 1, 1, 32'h80000b00);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check_out("t6_idle", 3'b000, 0, 0, 0, 0);
`ifdef REDIRECT_PERF_EN
        check_val("perf_branch_cnt", perf_branch_cnt, 32'd2);
        check_val("perf_trap_cnt",   perf_trap_cnt,   32'd1);
        check_val("perf_drain_cyc",  perf_drain_cyc,  32'd5);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
